abc_stim_gen: RTL and testbench
===============================

// Module: abc_stim_gen
// PURPOSE
//  Upstream stimulus stage for the combinational lab DUTs (e.g. the 3-input a/b/y -> good checker).
//  Sweeps every WIDTH-bit input pattern, holding each for HOLD clocks, for PASSES full sweeps.
//  Its outputs drive the DUT inputs directly. stim_valid qualifies DUT-output sampling by a bench or monitor.
//  Bit mapping: stim[0]=a (fastest), stim[1]=b, stim[2]=y (slowest).
// PARAMETERS
//  WIDTH   3  number of stimulus bits; sweep length = 2**WIDTH patterns
//  HOLD    2  clocks each pattern is held; legal range >=1
//  PASSES  1  full sweeps per start; 0 = run continuously until stop
// PORTS
//  clk          in   1      sampling/stimulus clock, rising edge
//  reset        in   1      asynchronous, active-high; clears all state
//  start        in   1      begin sweep; accepted only in IDLE or DONE
//  stop         in   1      abort sweep; accepted in RUN
//  stim         out  WIDTH  pattern driven to DUT inputs
//  stim_valid   out  1      high while in RUN; stim is stable and meaningful
//  pattern_idx  out  WIDTH  binary index of current pattern
//  sweep_done   out  1      one-cycle pulse on last hold cycle of each completed sweep
//  busy         out  1      high in RUN
//  done         out  1      level; high in DONE until next start or reset
// BEHAVIOUR
//  Clock and reset: one clock, clk. Reset is asynchronous, active-high, port name reset.
//  Reset values: all outputs 0. State IDLE. Hold count 0. Pass count 0.
//  FSM IDLE->RUN: on start. First stim appears in the cycle after start. pattern_idx=0, stim_valid=1.
//  FSM RUN->RUN: hold counter counts HOLD cycles per pattern, then idx increments.
//    - On expiry of the last pattern (idx=2**WIDTH-1), idx wraps to 0 if passes remain, or PASSES=0.
//  FSM RUN->DONE: final pattern's hold expires on the last pass.
//    - stim, pattern_idx and stim_valid go to 0. done=1. busy=0.
//  FSM DONE->RUN: on start. Behaves exactly as from IDLE; done clears the same cycle RUN begins.
//  FSM RUN->IDLE: on stop. Next cycle outputs return to 0. No sweep_done or done is produced.
//  sweep_done: asserted combinationally-registered in the final hold cycle of pattern 2**WIDTH-1.
//    - This holds on every pass, including the final one.
//  Simultaneous start and stop: stop wins. From IDLE/DONE with both high, the state does not change.
//  start while RUN: ignored; the sweep is not restarted.
//  HOLD=1: pattern changes every clock. sweep_done coincides with the single last-pattern cycle.
//  Counter widths:
//    - hold counter is $clog2(HOLD+1) bits.
//    - pass counter is $clog2(PASSES+1) bits, minimum 1.
//    - idx wraps naturally at WIDTH bits.
//  Reset mid-RUN: outputs are 0 immediately (asynchronous); no pulse is emitted.
//  Latency: start-to-first-stim is 1 clock. Sweep duration is 2**WIDTH*HOLD clocks per pass.
// CONFIGURATION
//  GRAY_ORDER_EN defined: stim = idx ^ (idx>>1). Consecutive patterns differ in exactly one bit.
//  GRAY_ORDER_EN undefined: stim = idx, ascending binary order.
//  In both modes pattern_idx stays binary, and sweep end is still idx=2**WIDTH-1.
// STRUCTURE
//  Package stim_pkg:
//    - typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} stim_state_e
//    - function bin2gray(logic [WIDTH-1:0])
//  Sub-module stim_hold_timer:
//    - load/count of HOLD cycles, emits expire pulse
//    - instantiated once
//  Top: FSM, idx register, pass counter, output registers.
// TESTING
//  1. Reset held 3 clocks, then released. Result: all outputs 0, state IDLE. start pulse gives next cycle stim=3'b000, stim_valid=1.
//  2. WIDTH=3, HOLD=2, PASSES=1. Result: stim 0,0,1,1,...,7,7 (16 clocks). sweep_done on the 16th. Then done=1, stim=0.
//  3. PASSES=2. Result: idx wraps 7->0 after 16 clocks with sweep_done pulse. Second pulse at clock 32, then DONE.
//  4. stop asserted at idx=3. Result: next cycle IDLE, stim_valid=0, done stays 0. start restarts at idx=0.
//  5. start+stop same cycle in IDLE: stays IDLE. Async reset asserted mid-cycle during RUN: outputs 0 before next edge.
//  6. GRAY_ORDER_EN defined: stim sequence 000,001,011,010,110,111,101,100. Check Hamming distance 1 between consecutive patterns.

Source files
------------

// File: rtl/abc_stim_gen_pkg.sv
// Shared types and helpers for the abc_stim_gen stimulus sweeper.
package stim_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} stim_state_e;

  localparam int STIM_MAX_W = 32;

  function automatic logic [STIM_MAX_W-1:0] bin2gray(input logic [STIM_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/abc_stim_gen_if.sv
// Control/stimulus bundle between the sweeper (master) and its consumer (slave).
interface abc_stim_gen_if #(parameter int WIDTH = 3);
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] stim;
  logic             stim_valid;
  logic [WIDTH-1:0] pattern_idx;
  logic             sweep_done;
  logic             busy;
  logic             done;

  modport master (input start, stop,
                  output stim, stim_valid, pattern_idx, sweep_done, busy, done);
  modport slave  (output start, stop,
                  input stim, stim_valid, pattern_idx, sweep_done, busy, done);
endinterface

// File: rtl/abc_stim_gen_hold_timer.sv
// Counts HOLD cycles per pattern; o_expire marks the last hold cycle.
module stim_hold_timer #(
  parameter int HOLD = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int HW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
  localparam logic [HW-1:0] LAST = HW'(HOLD - 1);

  logic [HW-1:0] r_cnt;

  assign o_expire = i_en && (r_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_cnt <= '0;
    else if (i_clr)    r_cnt <= '0;
    else if (i_en)     r_cnt <= o_expire ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/abc_stim_gen.sv
// Sweeps all WIDTH-bit patterns, HOLD clocks each, PASSES times (0 = forever).
// Define GRAY_ORDER_EN to drive stim in Gray order; pattern_idx stays binary.
module abc_stim_gen
  import stim_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int HOLD   = 2,
  parameter int PASSES = 1
) (
  input  logic           clk,
  input  logic           reset,
  abc_stim_gen_if.master bus
);
  localparam int PW = (PASSES < 1) ? 1 : $clog2(PASSES + 1);
  localparam logic [PW-1:0]    LAST_PASS = PW'((PASSES < 1) ? 0 : PASSES - 1);
  localparam logic [WIDTH-1:0] LAST_IDX  = '1;
  localparam bit               CONT      = (PASSES == 0);

  stim_state_e      r_state, w_state_nxt;
  logic [WIDTH-1:0] r_idx, w_idx_nxt;
  logic [PW-1:0]    r_pass, w_pass_nxt;
  logic             w_run, w_expire, w_last_pat, w_final;

  assign w_run      = (r_state == ST_RUN);
  assign w_last_pat = (r_idx == LAST_IDX);
  assign w_final    = w_last_pat && !CONT && (r_pass == LAST_PASS);

  // Timer is held clear outside RUN so every sweep starts with a full hold.
  stim_hold_timer #(.HOLD(HOLD)) u_hold (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (!w_run || bus.stop),
    .i_en     (w_run),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pass_nxt  = r_pass;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.start && !bus.stop) begin
          w_state_nxt = ST_RUN;
          w_idx_nxt   = '0;
          w_pass_nxt  = '0;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
          w_pass_nxt  = '0;
        end else if (w_expire) begin
          if (w_final) begin
            w_state_nxt = ST_DONE;
            w_idx_nxt   = '0;
            w_pass_nxt  = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
            if (w_last_pat && !CONT) w_pass_nxt = r_pass + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_pass  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

  // Outputs decode registered state only, so async reset zeroes them at once.
  assign bus.stim_valid  = w_run;
  assign bus.busy        = w_run;
  assign bus.done        = (r_state == ST_DONE);
  assign bus.pattern_idx = r_idx;
  assign bus.sweep_done  = w_run && w_last_pat && w_expire;
`ifdef GRAY_ORDER_EN
  assign bus.stim = WIDTH'(bin2gray(STIM_MAX_W'(r_idx)));
`else
  assign bus.stim = r_idx;
`endif
endmodule

// File: tb/tb_abc_stim_gen.sv
// Self-checking bench: three sweeper configurations against a cycle-count reference model.
module tb_abc_stim_gen;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0;
  always #5 clk = ~clk;

  abc_stim_gen_if #(.WIDTH(3)) if0 ();
  abc_stim_gen_if #(.WIDTH(3)) if1 ();
  abc_stim_gen_if #(.WIDTH(3)) if2 ();

  abc_stim_gen #(.WIDTH(3), .HOLD(2), .PASSES(1)) u0 (.clk(clk), .reset(reset), .bus(if0));
  abc_stim_gen #(.WIDTH(3), .HOLD(1), .PASSES(2)) u1 (.clk(clk), .reset(reset), .bus(if1));
  abc_stim_gen #(.WIDTH(3), .HOLD(3), .PASSES(0)) u2 (.clk(clk), .reset(reset), .bus(if2));

  assign if0.start = start; assign if0.stop = stop;
  assign if1.start = start; assign if1.stop = stop;
  assign if2.start = start; assign if2.stop = stop;

  logic [2:0] o_stim [3];
  logic [2:0] o_idx  [3];
  logic       o_vld  [3], o_sd [3], o_busy [3], o_done [3];
  assign o_stim[0] = if0.stim; assign o_idx[0] = if0.pattern_idx; assign o_vld[0] = if0.stim_valid;
  assign o_sd[0] = if0.sweep_done; assign o_busy[0] = if0.busy; assign o_done[0] = if0.done;
  assign o_stim[1] = if1.stim; assign o_idx[1] = if1.pattern_idx; assign o_vld[1] = if1.stim_valid;
  assign o_sd[1] = if1.sweep_done; assign o_busy[1] = if1.busy; assign o_done[1] = if1.done;
  assign o_stim[2] = if2.stim; assign o_idx[2] = if2.pattern_idx; assign o_vld[2] = if2.stim_valid;
  assign o_sd[2] = if2.sweep_done; assign o_busy[2] = if2.busy; assign o_done[2] = if2.done;

  int hold_t [3] = '{2, 1, 3};
  int pass_t [3] = '{1, 2, 0};

  // Reference: a sweep is just "cycles since start"; everything follows from that count.
  bit   m_run  [3];
  bit   m_done [3];
  int   m_t    [3];
  bit   prev_vld  [3];
  logic [2:0] prev_stim [3];
  int   checks = 0, failures = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_run[k] = 0; m_done[k] = 0; m_t[k] = 0; prev_vld[k] = 0;
    end
  endtask

  task automatic model_edge(input bit s, input bit p);
    for (int k = 0; k < 3; k++) begin
      if (m_run[k]) begin
        if (p) begin
          m_run[k] = 0; m_t[k] = 0;
        end else begin
          m_t[k]++;
          if (pass_t[k] != 0 && m_t[k] == pass_t[k] * 8 * hold_t[k]) begin
            m_run[k] = 0; m_done[k] = 1; m_t[k] = 0;
          end
        end
      end else if (s && !p) begin
        m_run[k] = 1; m_done[k] = 0; m_t[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      int eidx, estim, esd, span;
      span  = 8 * hold_t[k];
      eidx  = m_run[k] ? (m_t[k] / hold_t[k]) % 8 : 0;
`ifdef GRAY_ORDER_EN
      estim = eidx ^ (eidx >> 1);
`else
      estim = eidx;
`endif
      esd   = (m_run[k] && (m_t[k] % span) == span - 1) ? 1 : 0;
      chk("stim",        k, 32'(o_stim[k]), estim);
      chk("pattern_idx", k, 32'(o_idx[k]),  eidx);
      chk("stim_valid",  k, 32'(o_vld[k]),  int'(m_run[k]));
      chk("busy",        k, 32'(o_busy[k]), int'(m_run[k]));
      chk("done",        k, 32'(o_done[k]), int'(m_done[k]));
      chk("sweep_done",  k, 32'(o_sd[k]),   esd);
`ifdef GRAY_ORDER_EN
      if (prev_vld[k] && o_vld[k] && o_stim[k] != prev_stim[k])
        chk("hamming", k, 32'($countones(o_stim[k] ^ prev_stim[k])), 1);
`endif
      prev_vld[k]  = o_vld[k];
      prev_stim[k] = o_stim[k];
    end
  endtask

  task automatic cyc(input bit s, input bit p);
    @(negedge clk);
    start = s;
    stop  = p;
    @(posedge clk);
    if (!reset) model_edge(s, p);
    #1 check_all();
  endtask

  initial begin
    model_reset();
    repeat (3) cyc(0, 0);
    @(negedge clk) reset = 1'b0;

    // Full sweeps: single pass, two passes at HOLD=1, continuous.
    cyc(1, 0);
    repeat (50) cyc(0, 0);

    // Simultaneous start/stop: stops the running one, leaves DONE ones alone.
    cyc(1, 1);
    cyc(0, 0);

    // Abort mid-sweep at idx 3 of the HOLD=2 unit, then restart.
    cyc(1, 0);
    repeat (6) cyc(0, 0);
    cyc(0, 1);
    repeat (2) cyc(0, 0);
    cyc(1, 1);
    cyc(1, 0);
    cyc(1, 0);
    repeat (3) cyc(0, 0);

    repeat (400) cyc($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);

    // Asynchronous reset between edges during RUN.
    cyc(0, 1);
    cyc(1, 0);
    repeat (5) cyc(0, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    repeat (2) cyc(0, 0);
    @(negedge clk) reset = 1'b0;
    cyc(1, 0);
    repeat (30) cyc(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
